// File: rtl/dmcache_fill_ctrl.sv
// Miss/fill sequencer for the two-read-port direct-mapped cache: round-robin
// arbitration of client misses onto one memory read port, with same-address merge.
module dmcache_fill_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        miss_req0,
    input  logic [15:0] miss_adr0,
    output logic        fill_done0,
    input  logic        miss_req1,
    input  logic [15:0] miss_adr1,
    output logic        fill_done1,
    output logic        fill_err,
    output logic [1:0]  err_port,
    output logic        mem_re,
    output logic [15:0] mem_raddr,
    input  logic [15:0] mem_data,
    input  logic        mem_valid,
    output logic [15:0] insert_adr,
    output logic [15:0] insert_data,
    output logic        insert_valid,
    output logic        busy
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_FILL  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t        state_q;
    logic          rr_q;
    logic          winner_q;
    logic [15:0]   cur_adr_q;
    logic [CW-1:0] wait_cnt_q;
    logic [CW-1:0] wait_cnt_d;
    logic          fill_done0_q;
    logic          fill_done1_q;
    logic          fill_err_q;
    logic [1:0]    err_port_q;
    logic          mem_re_q;
    logic [15:0]   mem_raddr_q;
    logic [15:0]   insert_adr_q;
    logic [15:0]   insert_data_q;
    logic          insert_valid_q;
    logic          busy_q;

    logic          any_req_s;
    logic          win_s;
    logic [15:0]   win_adr_s;
    logic          serve0_s;
    logic          serve1_s;

    // Arbitration, merge detection and wait counter increment.
    always_comb begin
        any_req_s  = miss_req0 | miss_req1;
        win_s      = 1'b0;
        if (miss_req0 && miss_req1) begin
            win_s = rr_q;
        end else begin
            win_s = miss_req1;
        end
        win_adr_s  = win_s ? miss_adr1 : miss_adr0;
        // A client is served if it won, or if it is currently missing on the same line.
        serve0_s   = (winner_q == 1'b0) || (miss_req0 && (miss_adr0 == cur_adr_q));
        serve1_s   = (winner_q == 1'b1) || (miss_req1 && (miss_adr1 == cur_adr_q));
        wait_cnt_d = wait_cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end

    // Sequencer state and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            rr_q           <= 1'b0;
            winner_q       <= 1'b0;
            cur_adr_q      <= 16'h0000;
            wait_cnt_q     <= '0;
            fill_done0_q   <= 1'b0;
            fill_done1_q   <= 1'b0;
            fill_err_q     <= 1'b0;
            err_port_q     <= 2'b00;
            mem_re_q       <= 1'b0;
            mem_raddr_q    <= 16'h0000;
            insert_adr_q   <= 16'h0000;
            insert_data_q  <= 16'h0000;
            insert_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            mem_re_q       <= 1'b0;
            insert_valid_q <= 1'b0;
            fill_done0_q   <= 1'b0;
            fill_done1_q   <= 1'b0;
            fill_err_q     <= 1'b0;
            err_port_q     <= 2'b00;
            case (state_q)
                S_IDLE: begin
                    if (any_req_s) begin
                        winner_q    <= win_s;
                        rr_q        <= ~win_s;
                        cur_adr_q   <= win_adr_s;
                        mem_re_q    <= 1'b1;
                        mem_raddr_q <= win_adr_s;
                        busy_q      <= 1'b1;
                        state_q     <= S_ISSUE;
                    end else begin
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    wait_cnt_q <= '0;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    wait_cnt_q <= wait_cnt_d;
                    if (mem_valid) begin
                        insert_valid_q <= 1'b1;
                        insert_adr_q   <= cur_adr_q;
                        insert_data_q  <= mem_data;
                        fill_done0_q   <= serve0_s;
                        fill_done1_q   <= serve1_s;
                        state_q        <= S_FILL;
                    end else if (wait_cnt_d == CW'(TIMEOUT)) begin
                        fill_err_q     <= 1'b1;
                        err_port_q     <= {serve1_s, serve0_s};
                        state_q        <= S_ERR;
                    end else begin
                        state_q        <= S_WAIT;
                    end
                end
                S_FILL: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_ERR: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign fill_done0   = fill_done0_q;
    assign fill_done1   = fill_done1_q;
    assign fill_err     = fill_err_q;
    assign err_port     = err_port_q;
    assign mem_re       = mem_re_q;
    assign mem_raddr    = mem_raddr_q;
    assign insert_adr   = insert_adr_q;
    assign insert_data  = insert_data_q;
    assign insert_valid = insert_valid_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_dmcache_fill_ctrl.sv
// Directed bench for dmcache_fill_ctrl: queue-driven clients, a latency-programmable
// memory responder, and a negedge monitor logging every strobe.
module tb_dmcache_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        miss_req0 = 1'b0;
    logic [15:0] miss_adr0 = 16'h0000;
    logic        fill_done0;
    logic        miss_req1 = 1'b0;
    logic [15:0] miss_adr1 = 16'h0000;
    logic        fill_done1;
    logic        fill_err;
    logic [1:0]  err_port;
    logic        mem_re;
    logic [15:0] mem_raddr;
    logic [15:0] mem_data = 16'h0000;
    logic        mem_valid = 1'b0;
    logic [15:0] insert_adr;
    logic [15:0] insert_data;
    logic        insert_valid;
    logic        busy;

    dmcache_fill_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .miss_req0(miss_req0), .miss_adr0(miss_adr0), .fill_done0(fill_done0),
        .miss_req1(miss_req1), .miss_adr1(miss_adr1), .fill_done1(fill_done1),
        .fill_err(fill_err), .err_port(err_port),
        .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_data(mem_data), .mem_valid(mem_valid),
        .insert_adr(insert_adr), .insert_data(insert_data), .insert_valid(insert_valid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Client address lists: main appends, drivers consume.
    logic [15:0] a0 [64];
    logic [15:0] a1 [64];
    int n0 = 0, n1 = 0, i0 = 0, i1 = 0;

    // Memory responder controls.
    int          mem_lat = 1;
    bit          mem_on = 1'b1;
    bit          fixed_en = 1'b0;
    logic [15:0] fixed_data = 16'h0000;
    int          stray_cnt = 0;

    // Monitor logs.
    int n_re = 0, n_ins = 0, n_err = 0, n_done0 = 0, n_done1 = 0;
    int re_cyc = 0, err_cyc = 0, done0_cyc = 0, done1_cyc = 0;
    logic [15:0] last_raddr = 16'h0000;
    logic [1:0]  last_err_port = 2'b00;
    logic [15:0] ins_adr_log [64];
    logic [15:0] ins_dat_log [64];
    int          ins_cyc_log [64];

    // Client 0: hold request and address until served or errored.
    initial forever begin
        @(negedge clk);
        if (miss_req0 && (fill_done0 || (fill_err && err_port[0]))) i0 = i0 + 1;
        if (i0 < n0) begin miss_req0 = 1'b1; miss_adr0 = a0[i0]; end
        else miss_req0 = 1'b0;
    end

    // Client 1: same protocol as client 0.
    initial forever begin
        @(negedge clk);
        if (miss_req1 && (fill_done1 || (fill_err && err_port[1]))) i1 = i1 + 1;
        if (i1 < n1) begin miss_req1 = 1'b1; miss_adr1 = a1[i1]; end
        else miss_req1 = 1'b0;
    end

    // Memory: answers each mem_re after mem_lat cycles; also fires stray valids on demand.
    initial begin
        int pend;
        int stray_done;
        logic [15:0] pend_adr;
        pend = 0;
        stray_done = 0;
        pend_adr = 16'h0000;
        forever begin
            @(negedge clk);
            mem_valid = 1'b0;
            if (!rst_n) pend = 0;
            else if (mem_re && mem_on) begin pend = mem_lat; pend_adr = mem_raddr; end
            else if (pend > 0) begin
                pend = pend - 1;
                if (pend == 0) begin
                    mem_valid = 1'b1;
                    mem_data  = fixed_en ? fixed_data : (pend_adr ^ 16'h5A5A);
                end
            end
            if (stray_cnt != stray_done) begin
                stray_done = stray_cnt;
                mem_valid  = 1'b1;
                mem_data   = 16'hDEAD;
            end
        end
    end

    // Output monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_re) begin n_re <= n_re + 1; re_cyc <= cyc; last_raddr <= mem_raddr; end
            if (insert_valid) begin
                ins_adr_log[n_ins] <= insert_adr;
                ins_dat_log[n_ins] <= insert_data;
                ins_cyc_log[n_ins] <= cyc;
                n_ins <= n_ins + 1;
            end
            if (fill_err) begin n_err <= n_err + 1; err_cyc <= cyc; last_err_port <= err_port; end
            if (fill_done0) begin n_done0 <= n_done0 + 1; done0_cyc <= cyc; end
            if (fill_done1) begin n_done1 <= n_done1 + 1; done1_cyc <= cyc; end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        n0 = i0;
        n1 = i1;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(2);
    endtask

    int t0, b_re, b_ins, b_err, b_d0, b_d1;

    task automatic snap();
        b_re = n_re; b_ins = n_ins; b_err = n_err; b_d0 = n_done0; b_d1 = n_done1;
    endtask

    initial begin
        wait_cyc(3);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_re", mem_re, 1'b0);
        chk("rst_ins_valid", insert_valid, 1'b0);
        chk("rst_raddr", mem_raddr, 16'h0000);
        chk("rst_ins_adr", insert_adr, 16'h0000);
        rst_n = 1'b1;
        wait_cyc(2);

        // Single miss, L=3.
        mem_lat = 3; fixed_en = 1'b1; fixed_data = 16'hBEEF;
        snap();
        sync();
        a0[n0] = 16'h1234; n0++;
        t0 = cyc;
        wait_cyc(10);
        chk("single_n_re", n_re - b_re, 1);
        chk("single_re_cyc", re_cyc - t0, 1);
        chk("single_raddr", last_raddr, 16'h1234);
        chk("single_n_ins", n_ins - b_ins, 1);
        chk("single_ins_adr", ins_adr_log[b_ins], 16'h1234);
        chk("single_ins_data", ins_dat_log[b_ins], 16'hBEEF);
        chk("single_done_cyc", done0_cyc - t0, 5);
        chk("single_n_done0", n_done0 - b_d0, 1);
        chk("single_n_done1", n_done1 - b_d1, 0);
        chk("single_busy_end", busy, 1'b0);
        fixed_en = 1'b0;

        // Contention from reset, then a single port-0 miss, then a second pair.
        do_reset();
        mem_lat = 1;
        snap();
        sync();
        a0[n0] = 16'h0010; n0++;
        a1[n1] = 16'h0020; n1++;
        wait_cyc(12);
        a0[n0] = 16'h0050; n0++;
        wait_cyc(8);
        a0[n0] = 16'h0060; n0++;
        a1[n1] = 16'h0070; n1++;
        wait_cyc(12);
        chk("cont_n_ins", n_ins - b_ins, 5);
        chk("cont_first", ins_adr_log[b_ins], 16'h0010);
        chk("cont_second", ins_adr_log[b_ins + 1], 16'h0020);
        chk("cont_single", ins_adr_log[b_ins + 2], 16'h0050);
        chk("cont_pair2_first", ins_adr_log[b_ins + 3], 16'h0070);
        chk("cont_pair2_second", ins_adr_log[b_ins + 4], 16'h0060);
        chk("cont_data", ins_dat_log[b_ins + 1], 16'h5A7A);

        // Simultaneous same-address merge.
        mem_lat = 2;
        snap();
        sync();
        a0[n0] = 16'h0042; n0++;
        a1[n1] = 16'h0042; n1++;
        wait_cyc(10);
        chk("merge_n_re", n_re - b_re, 1);
        chk("merge_n_ins", n_ins - b_ins, 1);
        chk("merge_n_done0", n_done0 - b_d0, 1);
        chk("merge_n_done1", n_done1 - b_d1, 1);
        chk("merge_same_cyc", done0_cyc - done1_cyc, 0);

        // Late merge: client 1 arrives while client 0 waits on memory.
        mem_lat = 3;
        snap();
        sync();
        a0[n0] = 16'h0042; n0++;
        t0 = cyc;
        wait_cyc(2);
        a1[n1] = 16'h0042; n1++;
        wait_cyc(10);
        chk("late_n_re", n_re - b_re, 1);
        chk("late_n_ins", n_ins - b_ins, 1);
        chk("late_n_done1", n_done1 - b_d1, 1);
        chk("late_done0_cyc", done0_cyc - t0, 5);
        chk("late_done1_cyc", done1_cyc - t0, 5);

        // Timeout: memory silent, TIMEOUT=4.
        mem_on = 1'b0;
        snap();
        sync();
        a0[n0] = 16'h0099; n0++;
        t0 = cyc;
        wait_cyc(10);
        chk("to_n_err", n_err - b_err, 1);
        chk("to_err_cyc", err_cyc - t0, 6);
        chk("to_err_port", last_err_port, 2'b01);
        chk("to_n_ins", n_ins - b_ins, 0);
        chk("to_n_done0", n_done0 - b_d0, 0);
        stray_cnt++;
        wait_cyc(4);
        chk("stray_n_ins", n_ins - b_ins, 0);
        chk("stray_busy", busy, 1'b0);
        chk("stray_n_re", n_re - b_re, 1);

        // Asynchronous reset while waiting on memory.
        sync();
        a0[n0] = 16'h0077; n0++;
        wait_cyc(3);
        chk("rstw_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        n0 = i0;
        #1;
        chk("rstw_busy", busy, 1'b0);
        chk("rstw_mem_re", mem_re, 1'b0);
        chk("rstw_ins_valid", insert_valid, 1'b0);
        chk("rstw_raddr", mem_raddr, 16'h0000);
        wait_cyc(3);
        rst_n = 1'b1;
        mem_on = 1'b1;
        mem_lat = 2;
        wait_cyc(2);
        snap();
        sync();
        a1[n1] = 16'h0005; n1++;
        t0 = cyc;
        wait_cyc(10);
        chk("rstw_n_re", n_re - b_re, 1);
        chk("rstw_n_ins", n_ins - b_ins, 1);
        chk("rstw_ins_adr", ins_adr_log[b_ins], 16'h0005);
        chk("rstw_ins_data", ins_dat_log[b_ins], 16'h5A5F);
        chk("rstw_done1_cyc", done1_cyc - t0, 4);
        chk("rstw_n_done0", n_done0 - b_d0, 0);

        // Back-to-back misses on client 0 with L=1: one fill every 4 cycles.
        mem_lat = 1;
        snap();
        sync();
        for (int k = 0; k < 5; k++) begin
            a0[n0] = 16'h0100 + 16'(k);
            n0++;
        end
        wait_cyc(30);
        chk("b2b_n_ins", n_ins - b_ins, 5);
        chk("b2b_n_re", n_re - b_re, 5);
        chk("b2b_n_done0", n_done0 - b_d0, 5);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("b2b_adr%0d", k), ins_adr_log[b_ins + k], 16'h0100 + 16'(k));
            if (k > 0) chk($sformatf("b2b_gap%0d", k), ins_cyc_log[b_ins + k] - ins_cyc_log[b_ins + k - 1], 4);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
